// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Byte-enable patterns, MMIO word offsets and the store/load
//               enable legality check shared by the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    localparam int MMIO_LED    = 0;
    localparam int MMIO_CYCLE  = 1;
    localparam int MMIO_STATUS = 2;

    // The enabled lanes must be the ones the byte offset actually points at.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0:   ok = (addr_lo == 2'd0);
            BE_B1:   ok = (addr_lo == 2'd1);
            BE_B2:   ok = (addr_lo == 2'd2);
            BE_B3:   ok = (addr_lo == 2'd3);
            BE_H0:   ok = (addr_lo == 2'd0);
            BE_H1:   ok = (addr_lo == 2'd2);
            BE_W:    ok = (addr_lo == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// ============================================================================
// Module      : dmem_ram
// Description : Byte-lane writable single-port RAM, read-first, registered
//               read data with synchronous active-low output reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ram #(
    parameter int ADDR_W = 10,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [0:(1<<ADDR_W)-1];
    logic [XLEN-1:0] rdata_d;
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's write lands: read-first.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the RV32I core: RAM, legality
//               checking and an optional MMIO window (macro DMEM_MMIO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DMEM_WIDTH = 12,
    parameter int LED_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DMEM_WIDTH-1:0] dmem_addr,
    input  logic [XLEN-1:0]       dmem_data_in,
    input  logic                  rden_dmem,
    input  logic                  wren_dmem,
    input  logic [3:0]            mem_byte_mem,
    output logic [XLEN-1:0]       dmem_data_out,
    output logic [LED_WIDTH-1:0]  led,
    output logic                  err_dmem
);

`ifdef DMEM_MMIO_EN
    localparam int RAM_AW = DMEM_WIDTH - 3;
`else
    localparam int RAM_AW = DMEM_WIDTH - 2;
`endif

    logic              be_ok;
    logic              new_err;
    logic              mmio_sel;
    logic              ram_we;
    logic              ram_re;
    logic              err_d;
    logic              err_q;
    logic [XLEN-1:0]   ram_rdata;

    always_comb begin
        be_ok   = be_legal(mem_byte_mem, dmem_addr[1:0]);
        new_err = (wren_dmem && !be_ok) ||
                  (rden_dmem && (dmem_addr[1:0] != 2'd0) && (mem_byte_mem == BE_W));
`ifdef DMEM_MMIO_EN
        mmio_sel = dmem_addr[DMEM_WIDTH-1];
`else
        mmio_sel = 1'b0;
`endif
        ram_we = rst && wren_dmem && be_ok && !mmio_sel;
        ram_re = rst && rden_dmem && !mmio_sel;
    end

    dmem_ram #(
        .ADDR_W (RAM_AW),
        .XLEN   (XLEN)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .re    (ram_re),
        .we    (ram_we),
        .be    (mem_byte_mem),
        .addr  (dmem_addr[RAM_AW+1:2]),
        .wdata (dmem_data_in),
        .rdata (ram_rdata)
    );

`ifdef DMEM_MMIO_EN
    logic [LED_WIDTH-1:0]  led_d;
    logic [LED_WIDTH-1:0]  led_q;
    logic [XLEN-1:0]       cycle_d;
    logic [XLEN-1:0]       cycle_q;
    logic [XLEN-1:0]       mmio_rdata_d;
    logic [XLEN-1:0]       mmio_rdata_q;
    logic                  rd_mmio_d;
    logic                  rd_mmio_q;
    logic [DMEM_WIDTH-4:0] mmio_off;
    logic                  mmio_wr;
    logic                  err_clr;
    logic [XLEN-1:0]       lane_mask;
    logic [XLEN-1:0]       led_word;

    always_comb begin
        mmio_off     = dmem_addr[DMEM_WIDTH-2:2];
        mmio_wr      = wren_dmem && be_ok && mmio_sel;
        lane_mask    = {{8{mem_byte_mem[3]}}, {8{mem_byte_mem[2]}},
                        {8{mem_byte_mem[1]}}, {8{mem_byte_mem[0]}}};
        led_word     = (XLEN'(led_q) & ~lane_mask) | (dmem_data_in & lane_mask);
        led_d        = led_q;
        cycle_d      = cycle_q + 1'b1;
        err_clr      = 1'b0;
        rd_mmio_d    = rd_mmio_q;
        mmio_rdata_d = mmio_rdata_q;

        if (mmio_wr && (int'(mmio_off) == MMIO_LED)) begin
            led_d = led_word[LED_WIDTH-1:0];
        end
        if (mmio_wr && (int'(mmio_off) == MMIO_STATUS) &&
            mem_byte_mem[0] && dmem_data_in[0]) begin
            err_clr = 1'b1;
        end
        if (rden_dmem) begin
            rd_mmio_d = mmio_sel;
            if (mmio_sel) begin
                case (int'(mmio_off))
                    MMIO_LED:    mmio_rdata_d = XLEN'(led_q);
                    MMIO_CYCLE:  mmio_rdata_d = cycle_q;
                    MMIO_STATUS: mmio_rdata_d = XLEN'(err_q);
                    default:     mmio_rdata_d = '0;
                endcase
            end
        end
        // A fresh error wins over a clear landing in the same cycle.
        err_d = (err_q && !err_clr) || new_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q        <= '0;
            cycle_q      <= '0;
            mmio_rdata_q <= '0;
            rd_mmio_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            led_q        <= led_d;
            cycle_q      <= cycle_d;
            mmio_rdata_q <= mmio_rdata_d;
            rd_mmio_q    <= rd_mmio_d;
            err_q        <= err_d;
        end
    end

    assign dmem_data_out = rd_mmio_q ? mmio_rdata_q : ram_rdata;
    assign led           = led_q;
`else
    always_comb begin
        err_d = err_q || new_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign dmem_data_out = ram_rdata;
    assign led           = '0;
`endif

    assign err_dmem = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder (MMIO checks under
//               DMEM_MMIO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_data_in;
    logic        rden_dmem;
    logic        wren_dmem;
    logic [3:0]  mem_byte_mem;
    logic [31:0] dmem_data_out;
    logic [7:0]  led;
    logic        err_dmem;

    dmem_responder #(
        .XLEN       (32),
        .DMEM_WIDTH (12),
        .LED_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dmem_addr     (dmem_addr),
        .dmem_data_in  (dmem_data_in),
        .rden_dmem     (rden_dmem),
        .wren_dmem     (wren_dmem),
        .mem_byte_mem  (mem_byte_mem),
        .dmem_data_out (dmem_data_out),
        .led           (led),
        .err_dmem      (err_dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        bit          chk;
        string       tag;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [31:0] cnt_obs[$];
    logic [31:0] model_mem [0:1023];
    bit          rd_seen;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit tb_legal(input logic [3:0] be, input logic [1:0] off);
        return (be == (4'b0001 << off)) ||
               (be == 4'b0011 && off == 2'd0) ||
               (be == 4'b1100 && off == 2'd2) ||
               (be == 4'b1111 && off == 2'd0);
    endfunction

    function automatic bit is_mmio(input logic [11:0] a);
`ifdef DMEM_MMIO_EN
        return a[11];
`else
        return (a[11] && 1'b0);
`endif
    endfunction

    // One bus cycle; expected read data is queued before the model absorbs a write.
    task automatic cyc(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit chk, input logic [31:0] mexp,
                       input string tag);
        sb_t e;
        rden_dmem    = rd;
        wren_dmem    = wr;
        dmem_addr    = a;
        dmem_data_in = d;
        mem_byte_mem = be;
        if (rst) begin
            if (rd) begin
                e.exp = is_mmio(a) ? mexp : model_mem[a[11:2]];
                e.chk = chk;
                e.tag = tag;
                sb_q.push_back(e);
            end
            if (wr && tb_legal(be, a[1:0]) && !is_mmio(a)) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        rden_dmem = 1'b0;
        wren_dmem = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, 1'b1, a, d, be, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [11:0] a, input string tag);
        cyc(1'b1, 1'b0, a, 32'h0, 4'hF, 1'b1, 32'h0, tag);
    endtask

    task automatic rdm(input logic [11:0] a, input logic [31:0] exp, input bit chk, input string tag);
        cyc(1'b1, 1'b0, a, 32'h0, 4'hF, chk, exp, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 32'h0, "idle");
    endtask

    always @(posedge clk) rd_seen <= rden_dmem && rst;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk) check(mon_e.tag, dmem_data_out, mon_e.exp);
                else cnt_obs.push_back(dmem_data_out);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        rden_dmem    = 1'b0;
        wren_dmem    = 1'b0;
        dmem_addr    = '0;
        dmem_data_in = '0;
        mem_byte_mem = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", dmem_data_out, 32'h0);
        check("reset_led", {24'h0, led}, 32'h0);
        check("reset_err", {31'h0, err_dmem}, 32'h0);
        rst = 1'b1;
`ifndef DMEM_MMIO_EN
        wr(12'h800, 32'h0, 4'hF);
`endif
        // Initialise every word the reads below touch so X never enters the compare.
        wr(12'h010, 32'h0, 4'hF);
        wr(12'h040, 32'h0, 4'hF);

        wr(12'h010, 32'hDEADBEEF, 4'hF);
        rd(12'h010, "word_rd");
        idle(1);
        check("word_const", dmem_data_out, 32'hDEADBEEF);
        check("word_err", {31'h0, err_dmem}, 32'h0);

        wr(12'h020, 32'h0, 4'hF);
        wr(12'h020, 32'h000000AB, 4'b0001);
        wr(12'h022, 32'h12340000, 4'b1100);
        rd(12'h020, "lane_rd");
        idle(1);
        check("lane_const", dmem_data_out, 32'h123400AB);
        idle(3);
        check("hold", dmem_data_out, 32'h123400AB);

        wr(12'h030, 32'h11111111, 4'hF);
        cyc(1'b1, 1'b1, 12'h030, 32'h22222222, 4'hF, 1'b1, 32'h0, "rf_old");
        rd(12'h030, "rf_new");
        idle(1);
        check("rf_new_const", dmem_data_out, 32'h22222222);

        wr(12'h050, 32'h0, 4'hF);
        wr(12'h053, 32'hEE000000, 4'b1000);
        wr(12'h051, 32'h0000CD00, 4'b0010);
        rd(12'h050, "b1_b3");
        idle(1);

        wr(12'h040, 32'hCAFEF00D, 4'hF);
        check("err_pre", {31'h0, err_dmem}, 32'h0);
        wr(12'h041, 32'hFFFFFFFF, 4'hF);
        check("err_set", {31'h0, err_dmem}, 32'h1);
        rd(12'h040, "illegal_keep");
        idle(3);
        check("illegal_keep_const", dmem_data_out, 32'hCAFEF00D);
        check("err_sticky", {31'h0, err_dmem}, 32'h1);
        wr(12'h060, 32'h0, 4'hF);
        wr(12'h060, 32'hFFFFFFFF, 4'b0101);
        rd(12'h060, "bad_pattern");
        idle(1);

`ifdef DMEM_MMIO_EN
        wr(12'h800, 32'h000000A5, 4'b0001);
        check("led", {24'h0, led}, 32'h000000A5);
        rdm(12'h800, 32'h000000A5, 1'b1, "led_rd");
        rdm(12'h808, 32'h00000001, 1'b1, "status_rd");
        rdm(12'h80C, 32'h0, 1'b1, "unmapped_rd");
        rdm(12'h804, 32'h0, 1'b0, "cyc0");
        idle(9);
        rdm(12'h804, 32'h0, 1'b0, "cyc1");
        idle(1);
        if (cnt_obs.size() == 2) check("cyc_diff", cnt_obs[1] - cnt_obs[0], 32'd10);
        else check("cyc_samples", cnt_obs.size(), 32'd2);
        wr(12'h804, 32'hFFFFFFFF, 4'hF);
        wr(12'h808, 32'h00000001, 4'b0001);
        check("err_clr", {31'h0, err_dmem}, 32'h0);
`endif

        rst = 1'b0;
        wr(12'h800, 32'h00000055, 4'b0001);
        idle(1);
        check("rst_data", dmem_data_out, 32'h0);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_err", {31'h0, err_dmem}, 32'h0);
        rst = 1'b1;
`ifdef DMEM_MMIO_EN
        rdm(12'h804, 32'h0, 1'b1, "cnt_after_rst");
        rdm(12'h800, 32'h0, 1'b1, "led_after_rst");
`else
        rd(12'h800, "ram_after_rst");
`endif
        idle(1);
        check("led_after_rst_pin", {24'h0, led}, 32'h0);

        rd(12'h012, "illegal_rd_data");
        check("illegal_rd_err", {31'h0, err_dmem}, 32'h1);
        idle(1);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32I core.
- Answers the core's dmem requests: `dmem_addr`, `dmem_data_in`, `rden_dmem`, `wren_dmem`, `mem_byte_mem` in; `dmem_data_out` back.
- Contains byte-lane-writable RAM with one-cycle registered reads.
- Contains an optional memory-mapped I/O window: LED register, cycle counter, error status.
- Sits outside the core at top level, on the opposite side of the dmem interface.

Parameters:
- XLEN, 32, data word width.
- DMEM_WIDTH, 12, byte-address width; RAM holds 2^(DMEM_WIDTH-2) words.
- LED_WIDTH, 8, width of LED output register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- dmem_addr  input  DMEM_WIDTH  byte address; word index = dmem_addr[DMEM_WIDTH-1:2].
- dmem_data_in  input  XLEN  store data, already positioned in its byte lanes.
- rden_dmem  input  1  read request, single cycle.
- wren_dmem  input  1  write request, single cycle.
- mem_byte_mem  input  4  byte-lane enables; bit i selects bits 8i+7:8i.
- dmem_data_out  output  XLEN  registered full-word read data.
- led  output  LED_WIDTH  LED register.
- err_dmem  output  1  sticky illegal-access flag.

Behaviour:
- Reset, synchronous, active-low:
  - `dmem_data_out` = 0, `led` = 0, `err_dmem` = 0, cycle counter = 0.
  - RAM contents are not cleared.
  - Any request presented in a reset cycle is ignored.
- Read:
  - `rden_dmem` = 1 in cycle N → `dmem_data_out` carries the addressed word from cycle N+1.
  - Full word always returned; the core performs lane extraction and sign extension.
  - `dmem_data_out` holds its last value while `rden_dmem` = 0.
- Write:
  - `wren_dmem` = 1 with a legal enable pattern → the enabled lanes are written at the clock edge.
  - Disabled lanes are unchanged.
- Legal enable patterns:
  - 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - The pattern must also agree with `dmem_addr[1:0]`: byte at any offset; halfword lanes 0011 at offset 0 and 1100 at offset 2; word 1111 at offset 0.
- Illegal write (bad pattern or misaligned): write suppressed, `err_dmem` set the next cycle.
- Illegal read (`rden_dmem` with `dmem_addr[1:0]` ≠ 0 and `mem_byte_mem` = 1111): data still returned, `err_dmem` set.
- `err_dmem` is sticky. It clears only on reset or via the MMIO clear.
- Simultaneous `rden_dmem` and `wren_dmem`, same word: read-first; `dmem_data_out` returns the pre-write word.
- Back-to-back:
  - A write in cycle N followed by a read of the same word in cycle N+1 returns the new data.
  - No stall or busy signal exists; every request completes with fixed latency.
- Address wrap: bits above DMEM_WIDTH do not exist; no wrap logic required.
- Cycle counter:
  - Free-running XLEN-bit counter, +1 every non-reset cycle.
  - Wraps 0xFFFFFFFF → 0.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - `dmem_addr[DMEM_WIDTH-1]` = 1 selects the MMIO window; RAM is the lower half only.
  - Word offset 0: LED register, RW, low LED_WIDTH bits; upper bits read 0.
  - Word offset 1: cycle counter, RO; writes ignored.
  - Word offset 2: status, bit0 = `err_dmem`; writing 1 to bit0 with lane 0 enabled clears it. A clear in the same cycle as a new error leaves `err_dmem` = 1.
  - Other offsets read 0 and ignore writes.
  - MMIO reads have the same one-cycle latency as RAM.
- Undefined:
  - The whole address space is RAM.
  - `led` is tied to 0.
  - Cycle counter is not built.
  - `err_dmem` clears only on reset.

Decomposition:
- Package `dmem_pkg` holds:
  - byte-enable localparams (BE_B0..BE_B3, BE_H0, BE_H1, BE_W);
  - MMIO word-offset constants (MMIO_LED, MMIO_CYCLE, MMIO_STATUS);
  - pure function `be_legal(be, addr_lo)`.
- One sub-module: `dmem_ram`.
  - Byte-lane RAM with 4 enables, read-first, registered output.
  - Inferable as block RAM.
  - `dmem_responder` adds legality checking, MMIO decode and the output mux.

Test Plan:
- Word write then read: write 0xDEADBEEF to 0x010 with be=1111, then read 0x010 next cycle → `dmem_data_out` = 0xDEADBEEF one cycle after `rden_dmem`; `err_dmem` = 0.
- Byte lanes:
  - Write word 0x00000000 to 0x020.
  - Write byte 0x000000AB to 0x020 with be=0001.
  - Write halfword 0x12340000 to 0x022 with be=1100.
  - Read 0x020 → 0x123400AB.
- Read-first collision: 0x030 holds 0x11111111; drive read and write of 0x22222222 to 0x030 in the same cycle → output 0x11111111; next read → 0x22222222.
- Illegal write: write 0xFFFFFFFF to 0x041 with be=1111 → word 0x040 unchanged; `err_dmem` = 1 next cycle and stays 1 afterwards.
- MMIO (DMEM_MMIO_EN):
  - Write 0x000000A5 to the LED offset → `led` = 0xA5.
  - Two cycle-counter reads 10 cycles apart differ by 10.
  - Write 1 to status bit0 → `err_dmem` = 0.
- Reset mid-operation: assert `rst` = 0 during a write of 0x55 to the LED offset → `led` stays 0, `dmem_data_out` = 0, counter = 0 after release.
